// File: rtl/vector_alu_pipe_pkg.sv
// Shared types and defaults for the pipelined vector ALU.
package vector_alu_pkg;

  localparam int unsigned VALU_LANES = 16;
  localparam int unsigned VALU_LW    = 8;

  // Opcode encodings; 7 decodes to zero just like 0.
  typedef enum logic [2:0] {
    OpZero    = 3'd0,
    OpPassA   = 3'd1,
    OpAdd     = 3'd2,
    OpSub     = 3'd3,
    OpMul     = 3'd4,
    OpDiv     = 3'd5,
    OpMulH    = 3'd6,
    OpZeroAlt = 3'd7
  } valu_op_t;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StDiv  = 1'b1
  } valu_state_t;

endpackage

// File: rtl/vector_alu_pipe_if.sv
// Operand/result handshake bundle for vector_alu_pipe.
// master = producer of operands and consumer of results; slave = the ALU.
interface vector_alu_pipe_if
  import vector_alu_pkg::*;
#(
  parameter int unsigned LANES = VALU_LANES,
  parameter int unsigned LW    = VALU_LW
);

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*LW-1:0]   a;
  logic [LANES*LW-1:0]   b;
  logic [2:0]            op;
  logic                  sat;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*LW-1:0]   c;
  logic [LANES-1:0]      dz;

  modport master (
    output in_valid, a, b, op, sat, out_ready,
    input  in_ready, out_valid, c, dz
  );

  modport slave (
    input  in_valid, a, b, op, sat, out_ready,
    output in_ready, out_valid, c, dz
  );

endinterface

// File: rtl/vector_alu_pipe_lane_div.sv
// One lane of the iterative restoring divider: one quotient bit per step, MSB first.
module vector_lane_div #(
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  output logic [LW-1:0] q,
  output logic          dz
);

  logic [LW-1:0] rem_q, rem_d;
  logic [LW-1:0] quo_q, quo_d;
  logic [LW-1:0] dvs_q, dvs_d;

  logic [LW:0]   trial;
  logic [LW-1:0] rem_sub;
  logic          rem_sub_msb_unused;
  logic          fits;
  logic [LW-1:0] rem_nxt;
  logic [LW-1:0] quo_nxt;

  // Shift the next dividend bit (held in the quotient register's MSB) into the remainder.
  assign trial = {rem_q, quo_q[LW-1]};
  assign fits  = (trial >= {1'b0, dvs_q});
  // When the trial fits, trial - divisor < divisor, so the top bit is always zero.
  assign {rem_sub_msb_unused, rem_sub} = trial - {1'b0, dvs_q};
  assign rem_nxt = fits ? rem_sub : trial[LW-1:0];
  assign quo_nxt = {quo_q[LW-2:0], fits};

  assign dz = (dvs_q == '0);
  // Quotient after the step about to happen; a zero divisor forces all ones.
  assign q  = dz ? '1 : quo_nxt;

  // Next-state: load operands on start, otherwise advance one step per pulse.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (start) begin
      rem_d = '0;
      quo_d = a;
      dvs_d = b;
    end else if (step) begin
      rem_d = rem_nxt;
      quo_d = quo_nxt;
    end
  end

  // Lane divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/vector_alu_pipe.sv
// Handshaked vector ALU: single-cycle lane ops registered once, DIV as an LW-step divider.
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter int unsigned LANES = VALU_LANES,
  parameter int unsigned LW    = VALU_LW
) (
  input logic              clk,
  input logic              rst_n,
  vector_alu_pipe_if.slave bus
);

  localparam int unsigned W        = LANES * LW;
  localparam int unsigned CntW     = (LW > 2) ? $clog2(LW) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LW - 1);
  localparam logic [2*LW-1:0] RoundHalf = (2*LW)'(1) << (LW - 1);

  valu_state_t      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     c_q, c_d;
  logic [LANES-1:0] dz_q, dz_d;

  valu_op_t         op;
  logic             in_ready;
  logic             accept;
  logic             div_start;
  logic             div_step;
  logic [W-1:0]     alu_res;
  logic [W-1:0]     div_q;
  logic [LANES-1:0] div_dz;

  assign op        = valu_op_t'(bus.op);
  // The output slot is free or being drained this edge; never accept while dividing.
  assign in_ready  = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign div_start = accept && (op == OpDiv);
  assign div_step  = (state_q == StDiv);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LW-1:0]   la, lb, res;
    logic [LW:0]     sum, diff;
    logic [2*LW-1:0] prod, prod_rnd;
    logic [LW-1:0]   mulh, mulh_frac_unused;

    assign la   = bus.a[i*LW +: LW];
    assign lb   = bus.b[i*LW +: LW];
    assign sum  = {1'b0, la} + {1'b0, lb};
    // diff[LW] is the borrow out.
    assign diff = {1'b0, la} - {1'b0, lb};
    assign prod = {{LW{1'b0}}, la} * {{LW{1'b0}}, lb};
    // Rounded high half cannot overflow: (2^LW-1)^2 + 2^(LW-1) < 2^(2*LW).
    assign prod_rnd = prod + RoundHalf;
    assign {mulh, mulh_frac_unused} = prod_rnd;

    // Single-cycle lane result; DIV is produced by the lane divider instead.
    always_comb begin
      res = '0;
      case (op)
        OpPassA: res = la;
        OpAdd:   res = (bus.sat && sum[LW]) ? '1 : sum[LW-1:0];
        OpSub:   res = (bus.sat && diff[LW]) ? '0 : diff[LW-1:0];
        OpMul:   res = (bus.sat && (|prod[2*LW-1:LW])) ? '1 : prod[LW-1:0];
        OpMulH:  res = mulh;
        default: res = '0;
      endcase
    end

    assign alu_res[i*LW +: LW] = res;

    vector_lane_div #(
      .LW (LW)
    ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .start (div_start),
      .step  (div_step),
      .a     (la),
      .b     (lb),
      .q     (div_q[i*LW +: LW]),
      .dz    (div_dz[i])
    );
  end

  // FSM next-state and output-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    dz_d        = dz_q;
    unique case (state_q)
      StIdle: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (op == OpDiv) begin
            state_d     = StDiv;
            cnt_d       = '0;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            c_d         = alu_res;
            dz_d        = '0;
          end
        end
      end
      StDiv: begin
        cnt_d = cnt_q + 1'b1;
        // This edge performs the final step; capture the post-step quotient.
        if (cnt_q == CntLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          c_d         = div_q;
          dz_d        = div_dz;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, step counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      dz_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      dz_q        <= dz_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.dz        = dz_q;

endmodule
